oled_spi_receiver: RTL
======================

// Module: oled_spi_receiver
// PURPOSE
//   Display-side end of the OLED SPI link: deserialises spi_cs/spi_clk/spi_mosi/oled_dc into bytes.
//   Each byte is tagged command (dc=0) or data (dc=1) and queued in a small FIFO behind a valid/ready port.
//   Used as an on-chip loopback checker and as the bench-side model for the OLED controller.
//   All SPI inputs are asynchronous to clk and are oversampled.
// PARAMETERS
//   FIFO_DEPTH  4  entries of {dc,data}; power of two, >=2
//   SYNC_STAGES 2  synchroniser flops per SPI input; >=2
// PORTS
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   spi_cs       in   1  chip select, active low
//   spi_clk      in   1  SPI clock, mode 0: idle low, sample on rising edge
//   spi_mosi     in   1  serial data, MSB first
//   oled_dc      in   1  0=command, 1=data; sampled with bit 0 of each byte
//   oled_res     in   1  display reset, active low; low flushes the receiver
//   out_valid    out  1  FIFO head valid
//   out_ready    in   1  consumer accepts head when out_valid&&out_ready
//   out_data     out  8  head byte
//   out_dc       out  1  head dc tag
//   overflow     out  1  sticky: a byte was dropped because the FIFO was full
//   frame_err    out  1  one-cycle pulse: cs deasserted with 1..7 bits shifted
//   display_on   out  1  decoded display state (see CONFIGURATION)
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_dc=0, overflow=0, frame_err=0, display_on=0.
//     Synchroniser flops load the idle values cs=1, sclk=0. Bit count=0. FIFO empty.
//   Sync: each input passes SYNC_STAGES flops. A rising edge is sync_sclk=1 with prev=0, qualified by sync_cs=0.
//   Timing: spi_clk high and low phases must each be >=3 clk periods. Faster input is out of contract.
//   Shift: on each qualified edge, shreg<={shreg[6:0],sync_mosi}, bitcnt++ (3-bit, wraps 7->0).
//   Byte complete: on the edge with bitcnt==7, {sync_dc,byte} is written next cycle.
//     The write happens if the FIFO is not full. If full, the byte is dropped and overflow<=1.
//   Latency: out_valid rises SYNC_STAGES+2 clk cycles after raw spi_clk rises for the 8th bit.
//     This holds only if the FIFO was empty.
//   FIFO: first-word fall-through.
//     Pop when out_valid&&out_ready.
//     A push and a pop in the same cycle are both honoured, including when full.
//     out_data/out_dc are stable while out_valid&&!out_ready.
//   cs rise (sync_cs 0->1): bitcnt<=0, shreg discarded.
//     frame_err pulses for 1 cycle iff bitcnt!=0. Queued bytes are unaffected.
//   oled_res low (synchronised): bitcnt<=0, FIFO flushed, out_valid<=0, display_on<=0.
//     Held while low. Edges are ignored. overflow is kept; only reset clears it.
//   SPI activity while reset=1 is ignored. Reset mid-byte loses the partial byte without a frame_err.
// CONFIGURATION
//   OLED_RX_CMD_DECODE_EN defined:
//     A command byte 0xAF at the FIFO write sets display_on=1; 0xAE clears it.
//     Decode happens at write, independent of out_ready.
//     Dropped (overflow) bytes are not decoded.
//   Undefined: display_on tied 0 and no decode logic is built.
// STRUCTURE
//   Package oled_pkg holds:
//     OLED_CMD_DISPLAY_OFF=8'hAE and OLED_CMD_DISPLAY_ON=8'hAF
//     typedef oled_rx_byte_t = struct packed {logic dc; logic [7:0] data;}
//   Sub-module oled_rx_fifo: FWFT FIFO, parameter DEPTH, with push/full/pop/empty.
//   Synchroniser, edge detect, shifter and decode stay inline.
// TESTING
//   1 Send cmd 0xA5 (dc=0), sclk half-period 4 clk, out_ready=1:
//     out_valid for 1 cycle with out_data=0xA5, out_dc=0, 4 cycles after the 8th raw rise.
//   2 With out_ready=0, send data bytes 0x01..0x05 (dc=1), FIFO_DEPTH=4:
//     0x01..0x04 held and overflow=1.
//     Then out_ready=1 pops 0x01,0x02,0x03,0x04 in order.
//   3 Send 5 bits then raise cs:
//     frame_err pulses once and nothing is queued.
//     Next full byte 0x3C is received intact.
//   4 Queue 2 bytes, pulse oled_res low 10 clk:
//     out_valid=0 and the FIFO is empty. overflow is unchanged.
//     Next byte 0x7E is received alone.
//   5 With OLED_RX_CMD_DECODE_EN, send cmd 0xAF:
//     display_on=1. Then data 0xAE (dc=1) leaves display_on=1. Then cmd 0xAE gives 0.
//   6 Assert reset mid-byte after 3 bits, release, then send 0x81:
//     all outputs are 0 during reset and exactly 0x81 is received afterwards.

Source files
------------

// File: rtl/oled_spi_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : oled_pkg                                                       |
// | Purpose   : Shared command codes and FIFO entry type for the OLED receiver.|
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package oled_pkg;

    localparam logic [7:0] OLED_CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OLED_CMD_DISPLAY_ON  = 8'hAF;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } oled_rx_byte_t;

endpackage
`default_nettype wire

// File: rtl/oled_spi_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : oled_spi_receiver_if                                           |
// | Purpose   : Valid/ready byte stream leaving the OLED SPI receiver.         |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface oled_spi_receiver_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_dc;

    modport master (
        output out_valid,
        output out_data,
        output out_dc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_dc,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/oled_spi_receiver_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : oled_rx_fifo                                                   |
// | Purpose   : First-word fall-through FIFO of {dc,data} entries.             |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module oled_rx_fifo
    import oled_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          clear,
    input  wire logic          push,
    input  oled_rx_byte_t      push_data,
    output logic               full,
    input  wire logic          pop,
    output logic               empty,
    output oled_rx_byte_t      head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    oled_rx_byte_t  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
    assign push_ok = push && !clear && (!full || pop);
    assign pop_ok  = pop && !clear && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (!push_ok && pop_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/oled_spi_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : oled_spi_receiver                                              |
// | Purpose   : Oversampling SPI mode-0 deserialiser with dc tag and FIFO.     |
// |             Define OLED_RX_CMD_DECODE_EN to build display on/off decode.   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            spi_cs,
    input  wire logic            spi_clk,
    input  wire logic            spi_mosi,
    input  wire logic            oled_dc,
    input  wire logic            oled_res,
    oled_spi_receiver_if.master  out_if,
    output logic                 overflow,
    output logic                 frame_err,
    output logic                 display_on
);

    // Bit order of the synchroniser bundle: {res, dc, mosi, sclk, cs}
    localparam logic [4:0] SYNC_IDLE = 5'b10001;

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]     raw_in;
    logic           sync_cs;
    logic           sync_sclk;
    logic           sync_mosi;
    logic           sync_dc;
    logic           res_low;
    logic           prev_sclk;
    logic           prev_cs;
    logic           sclk_rise;
    logic           cs_rise;
    logic [2:0]     bitcnt;
    logic [6:0]     shreg;
    logic           wr_pend;
    oled_rx_byte_t  wr_byte;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           push;
    oled_rx_byte_t  head;

    assign raw_in = {oled_res, oled_dc, spi_mosi, spi_clk, spi_cs};

    always_ff @(posedge clk) begin
        if (reset) sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end

    assign sync_cs   = sync_q[SYNC_STAGES-1][0];
    assign sync_sclk = sync_q[SYNC_STAGES-1][1];
    assign sync_mosi = sync_q[SYNC_STAGES-1][2];
    assign sync_dc   = sync_q[SYNC_STAGES-1][3];
    assign res_low   = !sync_q[SYNC_STAGES-1][4];

    assign sclk_rise = sync_sclk && !prev_sclk && !sync_cs;
    assign cs_rise   = sync_cs && !prev_cs;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sclk <= 1'b0;
            prev_cs   <= 1'b1;
            bitcnt    <= '0;
            shreg     <= '0;
            wr_pend   <= 1'b0;
            wr_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            prev_sclk <= sync_sclk;
            prev_cs   <= sync_cs;
            frame_err <= 1'b0;
            wr_pend   <= 1'b0;
            if (res_low) begin
                bitcnt <= '0;
            end else if (cs_rise) begin
                bitcnt    <= '0;
                frame_err <= (bitcnt != 3'd0);
            end else if (sclk_rise) begin
                shreg  <= {shreg[5:0], sync_mosi};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    wr_pend      <= 1'b1;
                    wr_byte.dc   <= sync_dc;
                    wr_byte.data <= {shreg, sync_mosi};
                end
            end
        end
    end

    assign pop  = out_if.out_valid && out_if.out_ready;
    assign push = wr_pend && !res_low;

    oled_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (res_low),
        .push      (push),
        .push_data (wr_byte),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head.data;
    assign out_if.out_dc    = head.dc;

    always_ff @(posedge clk) begin
        if (reset)                          overflow <= 1'b0;
        else if (push && fifo_full && !pop) overflow <= 1'b1;
    end

`ifdef OLED_RX_CMD_DECODE_EN
    logic push_ok;
    assign push_ok = push && (!fifo_full || pop);

    // Decode only bytes that actually enter the FIFO, so dropped bytes are ignored.
    always_ff @(posedge clk) begin
        if (reset || res_low) begin
            display_on <= 1'b0;
        end else if (push_ok && !wr_byte.dc) begin
            if (wr_byte.data == OLED_CMD_DISPLAY_ON)       display_on <= 1'b1;
            else if (wr_byte.data == OLED_CMD_DISPLAY_OFF) display_on <= 1'b0;
        end
    end
`else
    assign display_on = 1'b0;
`endif

endmodule
`default_nettype wire
